// File: rtl/ws2812_pkg.sv
// Shared types, 12 MHz timing defaults and colour reordering for the
// WS2812 chain driver.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        LATCH
    } state_t;

    localparam int DEF_BIT_CYC   = 15;
    localparam int DEF_T0H_CYC   = 4;
    localparam int DEF_T1H_CYC   = 8;
    localparam int DEF_LATCH_CYC = 600;

    // LEDs expect green first on the wire
    function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// Single WS2812 bit shaper: high for T0H/T1H cycles, low for the rest
// of BIT_CYC. bit_last flags the second-to-last cycle of a bit.
module ws2812_bit_tx
    import ws2812_pkg::*;
#(
    parameter int BIT_CYC = DEF_BIT_CYC,
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic data,
    output logic bit_last,
    output logic bit_end
);

    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] PRE  = CW'(BIT_CYC - 2);
    localparam logic [CW-1:0] HI0  = CW'(T0H_CYC);
    localparam logic [CW-1:0] HI1  = CW'(T1H_CYC);

    logic          active;
    logic          level;
    logic [CW-1:0] cyc;
    logic [CW-1:0] nxt;

    assign nxt = cyc + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            level  <= 1'b0;
            cyc    <= '0;
            data   <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            level  <= bit_val;
            cyc    <= '0;
            data   <= 1'b1;
        end else if (active) begin
            if (cyc == LAST) begin
                active <= 1'b0;
                cyc    <= '0;
                data   <= 1'b0;
            end else begin
                cyc  <= nxt;
                data <= nxt < (level ? HI1 : HI0);
            end
        end
    end

    assign bit_last = active && (cyc == PRE);
    assign bit_end  = active && (cyc == LAST);

endmodule

// File: rtl/ws2812_chain.sv
// WS2812 chain driver: frame buffer, queued refresh and latch gap.
// WS2812_CHAIN_AUTO_REFRESH_EN makes frames repeat continuously.
module ws2812_chain
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS  = 8,
    parameter int LED_W     = 8,
    parameter int BIT_CYC   = DEF_BIT_CYC,
    parameter int T0H_CYC   = DEF_T0H_CYC,
    parameter int T1H_CYC   = DEF_T1H_CYC,
    parameter int LATCH_CYC = DEF_LATCH_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [23:0]      rgb_data,
    input  logic [LED_W-1:0] led_num,
    input  logic             write,
    input  logic             refresh,
    output logic             data,
    output logic             busy,
    output logic             frame_done
);

    localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int LW = $clog2(LATCH_CYC + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_LEDS - 1);
    localparam logic [LW-1:0] LATCH_END = LW'(LATCH_CYC);

    logic [23:0] frame_buf [NUM_LEDS];

    state_t        state, state_d;
    logic [IW-1:0] idx, idx_d;
    logic [4:0]    bitn, bitn_d;
    logic [23:0]   shreg, shreg_d;
    logic [LW-1:0] lcnt, lcnt_d;
    logic          pending, pending_d;
    logic          done_d;
    logic          go;
    logic          start;
    logic          bit_val;
    logic          bit_last;
    logic          bit_end;
    logic [23:0]   grb;

`ifdef WS2812_CHAIN_AUTO_REFRESH_EN
    assign go = 1'b1;
`else
    assign go = refresh | pending;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) frame_buf[i] <= '0;
        end else if (write && (32'(led_num) < NUM_LEDS)) begin
            frame_buf[led_num[IW-1:0]] <= rgb_data;
        end
    end

    assign grb  = rgb_to_grb(frame_buf[idx]);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            bitn       <= '0;
            shreg      <= '0;
            lcnt       <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            bitn       <= bitn_d;
            shreg      <= shreg_d;
            lcnt       <= lcnt_d;
            pending    <= pending_d;
            frame_done <= done_d;
        end
    end

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        bitn_d    = bitn;
        shreg_d   = shreg;
        lcnt_d    = lcnt;
        pending_d = pending | (refresh && busy);
        done_d    = 1'b0;
        start     = 1'b0;
        bit_val   = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_d   = LOAD;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end
            // Overlaps the final cycle of the previous LED's last bit
            LOAD: begin
                start   = 1'b1;
                bit_val = grb[23];
                shreg_d = grb;
                bitn_d  = 5'd23;
                state_d = SEND;
            end
            SEND: begin
                if (bit_last && bitn == 5'd0) begin
                    if (idx != LAST_IDX) begin
                        idx_d   = idx + IW'(1);
                        state_d = LOAD;
                    end else begin
                        lcnt_d  = '0;
                        state_d = LATCH;
                    end
                end else if (bit_end && bitn != 5'd0) begin
                    start   = 1'b1;
                    bit_val = shreg[bitn - 5'd1];
                    bitn_d  = bitn - 5'd1;
                end
            end
            LATCH: begin
                if (lcnt == LATCH_END) begin
                    done_d = 1'b1;
                    if (go) begin
                        state_d   = LOAD;
                        idx_d     = '0;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    lcnt_d = lcnt + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    ws2812_bit_tx #(
        .BIT_CYC (BIT_CYC),
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC)
    ) u_bit_tx (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bit_val  (bit_val),
        .data     (data),
        .bit_last (bit_last),
        .bit_end  (bit_end)
    );

endmodule
